// File: rtl/pipe_pkg.sv
// Shared limits and helpers for the pipe_chain register pipeline.
//   WIDTH_MIN/WIDTH_MAX : legal range of payload width
//   DEPTH_MIN/DEPTH_MAX : legal range of stage count
//   occ_width()         : bits needed to hold a stage count 0..depth
package pipe_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 1024;
    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 16;

    // Width of an occupancy counter able to represent 0..depth.
    function automatic int unsigned occ_width(input int unsigned depth);
        return int'($clog2(depth + 1));
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// One valid/ready register stage of pipe_chain.
//   clk, rst_n           : clock, synchronous active-low reset
//   flush                : drop the stored beat
//   in_valid/in_ready_c  : upstream handshake (in_ready_c is combinational)
//   in_data              : upstream payload
//   out_valid/out_ready  : downstream handshake (out_valid registered)
//   out_data             : stored payload (registered)
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready_c,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             load_c;

    // Ready when empty or when the held beat leaves this cycle; payload
    // only loads on an actual transfer in.
    always_comb begin
        in_ready_c = !valid_q || out_ready;
        load_c     = in_valid && in_ready_c && !flush;
        valid_d    = valid_q;
        data_d     = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_c) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/pipe_chain.sv
// Parameterised valid/ready register pipeline with bubble compression,
// full-rate throughput and flush.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : discard every stored beat
//   data_in/in_valid    : upstream beat
//   in_ready            : combinational accept (no path from in_valid)
//   data_out/valid      : head-of-chain beat (registered)
//   out_ready           : downstream accept
//   occupancy           : number of stages holding a beat
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              data_out,
    output logic                          valid,
    input  logic                          out_ready,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX ||
        WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_param
        $error("pipe_chain: illegal parameters DEPTH=%0d WIDTH=%0d", DEPTH, WIDTH);
    end

    // Index k is the boundary in front of stage k; index DEPTH is the output.
    logic [DEPTH:0]   vld;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] dat [DEPTH+1];

    assign vld[0]     = in_valid;
    assign dat[0]     = data_in;
    assign rdy[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_slice #(
            .WIDTH(WIDTH)
        ) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .in_valid   (vld[k]),
            .in_ready_c (rdy[k]),
            .in_data    (dat[k]),
            .out_valid  (vld[k+1]),
            .out_ready  (rdy[k+1]),
            .out_data   (dat[k+1])
        );
    end

    // Input is closed during reset and flush so a beat is never half-taken.
    assign in_ready = rst_n && rdy[0] && !flush;
    assign valid    = vld[DEPTH];
    assign data_out = dat[DEPTH];

    // Popcount of the stage valid flags.
    always_comb begin
        occupancy = OCC_W'($countones(vld[DEPTH:1]));
    end

endmodule

// File: tb/tb_pipe_chain.sv
module tb_pipe_chain;

    logic clk;
    logic rst_n;

    // DEPTH=2 instance: directed scenarios
    logic       fl2, iv2, ir2, v2, or2;
    logic [7:0] d2, do2;
    logic [1:0] oc2;

    // DEPTH=1 and DEPTH=16 instances: random traffic
    logic       fl1, iv1, ir1, v1, or1;
    logic [7:0] di1, do1;
    logic [0:0] oc1;
    logic       fl16, iv16, ir16, v16, or16;
    logic [7:0] di16, do16;
    logic [4:0] oc16;

    int n_tests;
    int n_fail;

    logic [7:0] q2[$];
    logic [7:0] q1[$];
    logic [7:0] q16[$];

    pipe_chain #(.WIDTH(8), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(fl2), .data_in(d2), .in_valid(iv2),
        .in_ready(ir2), .data_out(do2), .valid(v2), .out_ready(or2), .occupancy(oc2)
    );

    pipe_chain #(.WIDTH(8), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(fl1), .data_in(di1), .in_valid(iv1),
        .in_ready(ir1), .data_out(do1), .valid(v1), .out_ready(or1), .occupancy(oc1)
    );

    pipe_chain #(.WIDTH(8), .DEPTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .flush(fl16), .data_in(di16), .in_valid(iv16),
        .in_ready(ir16), .data_out(do16), .valid(v16), .out_ready(or16), .occupancy(oc16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle on the DEPTH=2 instance; returns in_ready seen before the edge.
    task automatic drive2(input logic iv, input logic [7:0] d, input logic ordy,
                          input logic fl, output logic rdy);
        iv2 = iv; d2 = d; or2 = ordy; fl2 = fl;
        #1;
        rdy = ir2;
        if (v2 && or2) begin
            if (q2.size() == 0) check("d2_unexpected_beat", 32'(v2), 32'd0);
            else                check("d2_data", 32'(do2), 32'(q2.pop_front()));
        end
        if (iv2 && ir2) q2.push_back(d2);
        @(posedge clk); #1;
        if (fl) q2.delete();
        check("d2_occ", 32'(oc2), 32'(q2.size()));
    endtask

    // One cycle on the random instances using the inputs already driven.
    task automatic step_rand();
        #1;
        if (v1 && or1) begin
            if (q1.size() == 0) check("r1_unexpected_beat", 32'(v1), 32'd0);
            else                check("r1_data", 32'(do1), 32'(q1.pop_front()));
        end
        if (iv1 && ir1) q1.push_back(di1);
        if (v16 && or16) begin
            if (q16.size() == 0) check("r16_unexpected_beat", 32'(v16), 32'd0);
            else                 check("r16_data", 32'(do16), 32'(q16.pop_front()));
        end
        if (iv16 && ir16) q16.push_back(di16);
        @(posedge clk); #1;
        if (fl1)  q1.delete();
        if (fl16) q16.delete();
        check("r1_occ", 32'(oc1), 32'(q1.size()));
        check("r16_occ", 32'(oc16), 32'(q16.size()));
        check("r16_occ_le_depth", 32'(oc16 > 5'd16), 32'd0);
    endtask

    initial begin
        logic r;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        fl2 = 0; iv2 = 0; or2 = 0; d2 = '0;
        fl1 = 0; iv1 = 0; or1 = 0; di1 = '0;
        fl16 = 0; iv16 = 0; or16 = 0; di16 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(ir2), 32'd0);
        check("rst_valid", 32'(v2), 32'd0);
        check("rst_data", 32'(do2), 32'd0);
        check("rst_occ", 32'(oc2), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(ir2), 32'd1);

        // Back-to-back stream, latency and peak occupancy
        drive2(1'b1, 8'h11, 1'b1, 1'b0, r);
        check("t1_valid_e0", 32'(v2), 32'd0);
        drive2(1'b1, 8'h22, 1'b1, 1'b0, r);
        check("t1_valid_e1", 32'(v2), 32'd1);
        check("t1_head", 32'(do2), 32'h11);
        check("t1_occ_peak", 32'(oc2), 32'd2);
        drive2(1'b1, 8'h33, 1'b1, 1'b0, r);
        check("t1_second", 32'(do2), 32'h22);
        drive2(1'b0, 8'h00, 1'b1, 1'b0, r);
        check("t1_third", 32'(do2), 32'h33);
        drive2(1'b0, 8'h00, 1'b1, 1'b0, r);
        check("t1_empty", 32'(v2), 32'd0);

        // Back-pressure: two accepted, head stable, then in-order drain
        drive2(1'b1, 8'h41, 1'b0, 1'b0, r);
        drive2(1'b1, 8'h42, 1'b0, 1'b0, r);
        check("t2_ready2", 32'(r), 32'd1);
        drive2(1'b1, 8'h43, 1'b0, 1'b0, r);
        check("t2_ready3", 32'(r), 32'd0);
        check("t2_hold3", 32'(do2), 32'h41);
        drive2(1'b1, 8'h44, 1'b0, 1'b0, r);
        check("t2_ready4", 32'(r), 32'd0);
        check("t2_hold4", 32'(do2), 32'h41);
        check("t2_valid4", 32'(v2), 32'd1);
        check("t2_full", 32'(oc2), 32'd2);
        repeat (3) drive2(1'b0, 8'h00, 1'b1, 1'b0, r);

        // Full chain with simultaneous in/out transfer
        drive2(1'b1, 8'h51, 1'b0, 1'b0, r);
        drive2(1'b1, 8'h52, 1'b0, 1'b0, r);
        drive2(1'b1, 8'h53, 1'b1, 1'b0, r);
        check("t3_ready_full", 32'(r), 32'd1);
        check("t3_occ", 32'(oc2), 32'd2);
        check("t3_head", 32'(do2), 32'h52);
        repeat (3) drive2(1'b0, 8'h00, 1'b1, 1'b0, r);

        // Flush: head delivered, input dropped, chain empty
        drive2(1'b1, 8'h61, 1'b0, 1'b0, r);
        drive2(1'b1, 8'h62, 1'b0, 1'b0, r);
        drive2(1'b1, 8'hAA, 1'b1, 1'b1, r);
        check("t4_ready_flush", 32'(r), 32'd0);
        check("t4_valid", 32'(v2), 32'd0);
        check("t4_occ", 32'(oc2), 32'd0);
        drive2(1'b0, 8'h00, 1'b1, 1'b0, r);
        check("t4_no_aa", 32'(v2), 32'd0);

        // Mid-stream reset with one beat stored
        drive2(1'b1, 8'h71, 1'b0, 1'b0, r);
        check("t5_occ1", 32'(oc2), 32'd1);
        rst_n = 1'b0;
        iv2 = 1'b0;
        #1;
        check("t5_ready_in_rst", 32'(ir2), 32'd0);
        @(posedge clk); #1;
        q2.delete();
        check("t5_valid", 32'(v2), 32'd0);
        check("t5_data", 32'(do2), 32'd0);
        check("t5_occ", 32'(oc2), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            drive2(1'b0, 8'h00, 1'b1, 1'b0, r);
            check("t5_no_stale", 32'(v2), 32'd0);
        end

        // Random traffic on DEPTH=1 and DEPTH=16
        for (int c = 0; c < 10000; c++) begin
            iv1  = 1'($urandom_range(0, 1));
            di1  = 8'($urandom);
            or1  = ($urandom_range(0, 3) != 0);
            fl1  = ($urandom_range(0, 127) == 0);
            iv16 = ($urandom_range(0, 3) != 0);
            di16 = 8'($urandom);
            or16 = ($urandom_range(0, 2) == 0);
            fl16 = ($urandom_range(0, 255) == 0);
            step_rand();
        end
        iv1 = 0; iv16 = 0; fl1 = 0; fl16 = 0; or1 = 1; or16 = 1;
        repeat (20) step_rand();
        check("r1_drained", 32'(q1.size()), 32'd0);
        check("r16_drained", 32'(q16.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
